// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IMem address drive and IF/ID register.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        stall,
  input  logic        IF_Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] JR_Target,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Data,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_Plus4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Cycles,
`endif
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_JR     = 2'b11
  } pc_src_e;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  pc_src_e     w_src;

  assign w_src      = pc_src_e'(PCSrc);
  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect targets are word-aligned on the way in; the sequential path is left as-is.
  always_comb begin
    w_pc_next = w_pc_plus4;
    unique case (w_src)
      SRC_SEQ:    w_pc_next = w_pc_plus4;
      SRC_BRANCH: w_pc_next = {Branch_Target[31:2], 2'b00};
      SRC_JUMP:   w_pc_next = {Jump_Target[31:2], 2'b00};
      SRC_JR:     w_pc_next = {JR_Target[31:2], 2'b00};
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (PCWrite) begin
      r_pc <= w_pc_next;
    end
  end

  // Stall wins over flush so an instruction waiting in ID is never replaced by a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_pc_plus4 <= w_pc_plus4;
      if (IF_Flush) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_instr <= IMem_Data;
        r_valid <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (IF_Flush && !stall)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Cycles = r_stall_cnt;
  assign Flush_Cycles = r_flush_cnt;
`endif

  assign PC                = r_pc;
  assign IMem_Addr         = r_pc;
  assign IF_ID_Instruction = r_instr;
  assign IF_ID_PC_Plus4    = r_pc_plus4;
  assign IF_ID_Valid       = r_valid;

endmodule
